// File: rtl/ram_128x16_bist_if.sv
// RAM-side bus between the BIST controller and the 128x16 test-wrapped RAM.
// The master drives address, data, strobes and test_mode; the slave returns read data.
interface ram_128x16_bist_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_din;
  logic              ram_wr;
  logic              ram_oe;
  logic              ram_test_mode;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    output ram_a,
    output ram_din,
    output ram_wr,
    output ram_oe,
    output ram_test_mode,
    input  ram_dout
  );

  modport slave (
    input  ram_a,
    input  ram_din,
    input  ram_wr,
    input  ram_oe,
    input  ram_test_mode,
    output ram_dout
  );
endinterface

// File: rtl/ram_128x16_bist.sv
// BIST controller for the 128x16 test-wrapped RAM: checks the test_mode bypass
// path with four patterns, then runs March C- over every word and reports
// pass/fail with the first failing address, data and march element.
module ram_128x16_bist #(
  parameter int                ADDR_W  = 7,
  parameter int                DATA_W  = 16,
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] DATA_BG = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem,
  ram_128x16_bist_if.master ram
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BYP   = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0]        LAT    = 2'(RD_LAT);
  localparam logic [ADDR_W-1:0] A_LAST = '1;
  localparam logic [2:0]        E_DOWN = 3'd3;
  localparam logic [2:0]        E_LAST = 3'd5;

  logic [2:0] state;
  logic [2:0] elem;
  logic [1:0] wcnt;
  logic [1:0] pat;

  logic              cmp_now;
  logic              miscompare;
  logic              elem_up;
  logic              addr_last;
  logic              step_done;
  logic [ADDR_W-1:0] addr_step;
  logic [2:0]        elem_next;

  function automatic logic [DATA_W-1:0] byp_pat(input logic [1:0] p);
    case (p)
      2'd0:    return '0;
      2'd1:    return '1;
      2'd2:    return {(DATA_W/2){2'b10}};
      default: return {(DATA_W/2){2'b01}};
    endcase
  endfunction

  // Value expected on a read in element e (M2/M4 read the inverted background)
  function automatic logic [DATA_W-1:0] rd_val(input logic [2:0] e);
    return (e == 3'd2 || e == 3'd4) ? ~DATA_BG : DATA_BG;
  endfunction

  // Value written in element e (M1/M3 write the inverted background)
  function automatic logic [DATA_W-1:0] wr_val(input logic [2:0] e);
    return (e == 3'd1 || e == 3'd3) ? ~DATA_BG : DATA_BG;
  endfunction

  // Compare point, address stepping and end-of-address detection
  always_comb begin
    cmp_now    = ((state == S_BYP) || (state == S_RWAIT)) && (wcnt == LAT);
    miscompare = cmp_now && (ram.ram_dout != ram.ram_din);
    elem_up    = (elem < E_DOWN);
    addr_last  = elem_up ? (ram.ram_a == A_LAST) : (ram.ram_a == '0);
    addr_step  = elem_up ? ram.ram_a + 1'b1 : ram.ram_a - 1'b1;
    elem_next  = elem + 3'd1;
    // An address is finished after its write, or after its read in M5
    step_done  = (state == S_WR) ||
                 ((state == S_RWAIT) && (wcnt == LAT) && (elem == E_LAST) && !miscompare);
  end

  // Sequencer: state, registered RAM pins and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      elem              <= '0;
      wcnt              <= '0;
      pat               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      pass              <= 1'b0;
      fail_addr         <= '0;
      fail_data         <= '0;
      fail_elem         <= '0;
      ram.ram_a         <= '0;
      ram.ram_din       <= '0;
      ram.ram_wr        <= 1'b0;
      ram.ram_oe        <= 1'b0;
      ram.ram_test_mode <= 1'b0;
    end else begin
      ram.ram_wr <= 1'b0;
      ram.ram_oe <= 1'b0;
      if (miscompare) begin
        fail_addr         <= ram.ram_a;
        fail_data         <= ram.ram_dout;
        fail_elem         <= (state == S_BYP) ? 3'd0 : elem;
        pass              <= 1'b0;
        busy              <= 1'b0;
        done              <= 1'b1;
        ram.ram_test_mode <= 1'b0;
        state             <= S_DONE;
      end else if (step_done) begin
        if (!addr_last) begin
          ram.ram_a <= addr_step;
          if (elem == 3'd0) begin
            ram.ram_din <= DATA_BG;
            ram.ram_wr  <= 1'b1;
            state       <= S_WR;
          end else begin
            ram.ram_din <= rd_val(elem);
            ram.ram_oe  <= 1'b1;
            state       <= S_RD;
          end
        end else if (elem == E_LAST) begin
          pass  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          // Every element after M0 opens with a read at its starting address
          elem        <= elem_next;
          ram.ram_a   <= (elem_next < E_DOWN) ? '0 : A_LAST;
          ram.ram_din <= rd_val(elem_next);
          ram.ram_oe  <= 1'b1;
          state       <= S_RD;
        end
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              busy              <= 1'b1;
              done              <= 1'b0;
              pass              <= 1'b0;
              fail_addr         <= '0;
              fail_data         <= '0;
              fail_elem         <= '0;
              ram.ram_a         <= '0;
              ram.ram_din       <= byp_pat(2'd0);
              ram.ram_test_mode <= 1'b1;
              pat               <= '0;
              wcnt              <= '0;
              state             <= S_BYP;
            end
          end
          S_BYP: begin
            if (wcnt != LAT) begin
              wcnt <= wcnt + 2'd1;
            end else if (pat == 2'd3) begin
              ram.ram_test_mode <= 1'b0;
              elem              <= '0;
              ram.ram_a         <= '0;
              ram.ram_din       <= DATA_BG;
              ram.ram_wr        <= 1'b1;
              state             <= S_WR;
            end else begin
              pat         <= pat + 2'd1;
              ram.ram_din <= byp_pat(pat + 2'd1);
              wcnt        <= '0;
            end
          end
          S_RD: begin
            wcnt  <= 2'd1;
            state <= S_RWAIT;
          end
          S_RWAIT: begin
            if (wcnt != LAT) begin
              wcnt <= wcnt + 2'd1;
            end else begin
              ram.ram_din <= wr_val(elem);
              ram.ram_wr  <= 1'b1;
              state       <= S_WR;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
